// File: rtl/hdmi_channel_scheduler_pkg.sv
// Shared constants, button FSM encoding and sample magnitude helper for the
// HDMI channel scheduler.
package hdmi_sched_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned VAL_W  = 12;
  localparam int unsigned PX_W   = 12;

  localparam logic [VAL_W-1:0] MAG_MAX = 12'd2047;

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StHeld,
    StDebRel
  } btn_state_e;

  // Absolute value of a two's complement sample; the most negative code has no
  // positive twin, so it clamps to MAG_MAX.
  function automatic logic [VAL_W-1:0] sat_mag(input logic [VAL_W-1:0] d);
    logic [VAL_W-1:0] neg;
    neg = ~d + 1'b1;
    if (d == {1'b1, {(VAL_W-1){1'b0}}}) begin
      sat_mag = MAG_MAX;
    end else begin
      sat_mag = d[VAL_W-1] ? neg : d;
    end
  endfunction

endpackage

// File: rtl/hdmi_channel_scheduler_if.sv
// Bus between the sample producers / video timing (master) and the scheduler
// (slave).
interface hdmi_channel_scheduler_if;
  import hdmi_sched_pkg::*;

  logic [NUM_CH-1:0]       smp_valid;
  logic [NUM_CH*VAL_W-1:0] smp_data;
  logic [NUM_CH-1:0]       smp_ready;
  logic                    btn_next;
  logic                    auto_en;
  logic [PX_W-1:0]         px_x;
  logic [PX_W-1:0]         px_y;
  logic                    data_en;
  logic [CH_W-1:0]         channel_select;
  logic [VAL_W-1:0]        val;
  logic                    frame_tick;

  modport master (
    output smp_valid, smp_data, btn_next, auto_en, px_x, px_y, data_en,
    input  smp_ready, channel_select, val, frame_tick
  );

  modport slave (
    input  smp_valid, smp_data, btn_next, auto_en, px_x, px_y, data_en,
    output smp_ready, channel_select, val, frame_tick
  );

endinterface

// File: rtl/hdmi_channel_scheduler_arb.sv
// Four-way round-robin arbiter. Grant is combinational from the request vector
// and a registered pointer that moves just past the last winner.
module hdmi_rr_arbiter4
  import hdmi_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_gnt_idx,
  output logic              o_gnt_vld
);

  logic [CH_W-1:0] r_ptr;
  logic [CH_W-1:0] w_idx;

  // Search from the pointer upward, wrapping 3 -> 0; nothing granted in reset.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = r_ptr;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_idx = r_ptr + CH_W'(i);
      if (!o_gnt_vld && !rst && i_req[w_idx]) begin
        o_gnt_vld    = 1'b1;
        o_gnt_idx    = w_idx;
        o_gnt[w_idx] = 1'b1;
      end
    end
  end

  // Pointer advances past the winner, holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_gnt_vld) begin
      r_ptr <= o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_channel_scheduler.sv
// Shares one peak-hold store between four sample producers and presents a
// frame-stable channel/peak pair to the renderer, updated only at frame start.
module hdmi_channel_scheduler
  import hdmi_sched_pkg::*;
#(
  parameter int unsigned AUTO_FRAMES     = 120,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic                      clk,
  input logic                      rst,
  hdmi_channel_scheduler_if.slave  io_sched
);

  localparam int unsigned FC_W = $clog2(AUTO_FRAMES + 1);
  localparam int unsigned DC_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(AUTO_FRAMES - 1);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] w_gnt;
  logic [CH_W-1:0]   w_gnt_idx;
  logic              w_gnt_vld;
  logic [VAL_W-1:0]  w_smp;
  logic [VAL_W-1:0]  w_mag;
  logic              w_fs;
  logic              w_adv;
  logic [CH_W-1:0]   w_next_sel;

  logic              r_btn_meta;
  logic              r_btn_sync;
  btn_state_e        r_state;
  logic [DC_W-1:0]   r_deb_cnt;
  logic              r_pending_adv;
  logic [FC_W-1:0]   r_frame_cnt;
  logic [CH_W-1:0]   r_sel;
  logic [VAL_W-1:0]  r_val;
  logic              r_tick;
  logic [VAL_W-1:0]  r_peak [NUM_CH];

  hdmi_rr_arbiter4 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (io_sched.smp_valid),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  assign io_sched.smp_ready      = w_gnt;
  assign io_sched.channel_select = r_sel;
  assign io_sched.val            = r_val;
  assign io_sched.frame_tick     = r_tick;

  assign w_smp = io_sched.smp_data[w_gnt_idx*VAL_W +: VAL_W];
  assign w_mag = sat_mag(w_smp);
  assign w_fs  = io_sched.data_en && (io_sched.px_x == '0) && (io_sched.px_y == '0);
  // Button and auto requests collapse into a single step.
  assign w_adv = r_pending_adv || (io_sched.auto_en && (r_frame_cnt == FC_LAST));
  assign w_next_sel = r_sel + CH_W'(w_adv);

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
    end else begin
      r_btn_meta <= io_sched.btn_next;
      r_btn_sync <= r_btn_meta;
    end
  end

  // Debounce FSM; an accepted press latches a pending advance until frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_deb_cnt     <= '0;
      r_pending_adv <= 1'b0;
    end else begin
      if (w_fs) r_pending_adv <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_btn_sync) begin
            r_state   <= StDebPress;
            r_deb_cnt <= '0;
          end
        end
        StDebPress: begin
          if (!r_btn_sync) begin
            r_state <= StIdle;
          end else if (r_deb_cnt == DC_LAST) begin
            r_state       <= StHeld;
            // Wins over the FS clear so a press completing on FS is not lost.
            r_pending_adv <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        StHeld: begin
          if (!r_btn_sync) begin
            r_state   <= StDebRel;
            r_deb_cnt <= '0;
          end
        end
        StDebRel: begin
          if (r_btn_sync) begin
            r_state <= StHeld;
          end else if (r_deb_cnt == DC_LAST) begin
            r_state <= StIdle;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Auto-rotate frame counter; any advance restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !io_sched.auto_en) begin
      r_frame_cnt <= '0;
    end else if (w_fs) begin
      r_frame_cnt <= w_adv ? '0 : r_frame_cnt + 1'b1;
    end
  end

  // Renderer-facing registers change only at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= '0;
      r_val  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_fs;
      if (w_fs) begin
        r_sel <= w_next_sel;
        r_val <= r_peak[w_next_sel];
      end
    end
  end

  // Peak hold; frame start clears, and a same-cycle sample seeds the new frame.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      if (rst) begin
        r_peak[ch] <= '0;
      end else if (w_fs) begin
        r_peak[ch] <= w_gnt[ch] ? w_mag : '0;
      end else if (w_gnt[ch] && (w_mag > r_peak[ch])) begin
        r_peak[ch] <= w_mag;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_channel_scheduler.sv
// Scoreboard bench: a driver runs a behavioural model and queues expected
// per-cycle outputs and frame events; a monitor pops and compares them.
module tb_hdmi_channel_scheduler;
  import hdmi_sched_pkg::*;

  localparam int DEB = 4;
  localparam int AF  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hdmi_channel_scheduler_if u_if ();

  hdmi_channel_scheduler #(
    .AUTO_FRAMES     (AF),
    .DEBOUNCE_CYCLES (DEB)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .io_sched (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] gnt; int sel; int val; bit tick; } cyc_t;
  typedef struct { int sel; int val; } frm_t;

  cyc_t q_cyc[$];
  frm_t q_frm[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Stimulus controls
  logic [3:0]  s_valid = '0;
  logic [11:0] s_data [4];
  bit          s_btn = 0, s_auto = 0, s_fs = 0;

  // Reference model state
  int m_ptr, m_sel, m_val, m_fcnt, m_run;
  int m_peak [4];
  bit m_tick, m_pend, m_lvl, m_b1, m_b2;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag_of(input logic [11:0] d);
    int v;
    v = int'(d);
    if (v >= 2048) v -= 4096;
    if (v < 0) v = -v;
    if (v > 2047) v = 2047;
    return v;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_val = 0; m_fcnt = 0; m_run = 0;
    m_tick = 0; m_pend = 0; m_lvl = 0; m_b1 = 0; m_b2 = 0;
    for (int i = 0; i < 4; i++) m_peak[i] = 0;
  endtask

  // Drive one cycle, predict it, queue expectations, advance past the edge.
  task automatic step();
    cyc_t c;
    frm_t f;
    int   g, ci, mg;
    bit   adv, syn;
    u_if.smp_valid = s_valid;
    for (int i = 0; i < 4; i++) u_if.smp_data[i*12 +: 12] = s_data[i];
    u_if.btn_next = s_btn;
    u_if.auto_en  = s_auto;
    if (s_fs) begin
      u_if.data_en = 1'b1; u_if.px_x = '0; u_if.px_y = '0;
    end else begin
      case ($urandom_range(0, 3))
        0: begin u_if.data_en = 1'b0; u_if.px_x = '0; u_if.px_y = '0; end
        1: begin u_if.data_en = 1'b1; u_if.px_x = '0; u_if.px_y = 12'($urandom_range(1, 4095)); end
        2: begin u_if.data_en = 1'b1; u_if.px_x = 12'($urandom_range(1, 4095)); u_if.px_y = '0; end
        default: begin
          u_if.data_en = 1'($urandom_range(0, 1));
          u_if.px_x = 12'($urandom_range(1, 4095)); u_if.px_y = 12'($urandom);
        end
      endcase
    end
    g = -1;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        ci = (m_ptr + i) % 4;
        if (g < 0 && s_valid[ci]) g = ci;
      end
    end
    c.gnt = (g < 0) ? 4'b0 : 4'(1 << g);
    c.sel = m_sel; c.val = m_val; c.tick = m_tick;
    q_cyc.push_back(c);
    if (rst) begin
      model_reset();
    end else begin
      m_tick = s_fs;
      if (s_fs) begin
        adv   = m_pend || (s_auto && m_fcnt == AF - 1);
        m_sel = (m_sel + int'(adv)) % 4;
        m_val = m_peak[m_sel];
        f.sel = m_sel; f.val = m_val;
        q_frm.push_back(f);
        for (int i = 0; i < 4; i++) m_peak[i] = 0;
        m_pend = 0;
        m_fcnt = adv ? 0 : m_fcnt + 1;
      end
      if (!s_auto) m_fcnt = 0;
      if (g >= 0) begin
        mg = mag_of(s_data[g]);
        if (mg > m_peak[g]) m_peak[g] = mg;
        m_ptr = (g + 1) % 4;
      end
      // Button level accepted once it differs for DEB+1 consecutive synced samples.
      syn = m_b2; m_b2 = m_b1; m_b1 = s_btn;
      if (syn != m_lvl) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_lvl = syn; m_run = 0;
          if (syn) m_pend = 1;
        end
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic fs_step();
    s_fs = 1; step(); s_fs = 0;
  endtask

  task automatic sample(input int ch, input logic [11:0] d);
    s_valid = 4'(1 << ch); s_data[ch] = d; step(); s_valid = '0;
  endtask

  task automatic press(input int n);
    s_btn = 1; repeat (n) step(); s_btn = 0; repeat (DEB + 4) step();
  endtask

  // Monitor: compare every cycle, and pop a frame event on each frame_tick.
  initial begin
    cyc_t c;
    frm_t f;
    forever begin
      @(negedge clk);
      if (q_cyc.size() > 0) begin
        c = q_cyc.pop_front();
        chk("smp_ready", 32'(u_if.smp_ready), int'(c.gnt));
        chk("channel_select", 32'(u_if.channel_select), c.sel);
        chk("val", 32'(u_if.val), c.val);
        chk("frame_tick", 32'(u_if.frame_tick), int'(c.tick));
        if (u_if.frame_tick === 1'b1) begin
          if (q_frm.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL frame_event: got tick expected none at %0t", $time);
          end else begin
            f = q_frm.pop_front();
            chk("frame_sel", 32'(u_if.channel_select), f.sel);
            chk("frame_val", 32'(u_if.val), f.val);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) s_data[i] = '0;
    u_if.smp_valid = '0; u_if.smp_data = '0; u_if.btn_next = 0; u_if.auto_en = 0;
    u_if.px_x = 12'd5; u_if.px_y = 12'd5; u_if.data_en = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    idle(2);
    rst = 0;

    // Arbitration: all valid rotates, then a lone requester wins every cycle
    for (int i = 0; i < 4; i++) s_data[i] = 12'($urandom);
    s_valid = 4'hF; idle(8);
    s_valid = 4'b0100; idle(3);
    s_valid = '0; idle(1);

    // Magnitude and saturation on channel 1
    fs_step(); press(10); fs_step();
    sample(1, 12'd100); sample(1, 12'hD44); sample(1, 12'h800);
    idle(2); fs_step(); idle(2); fs_step();

    // Glitch ignored, then presses step 1->2->3->0 only at frame start
    s_btn = 1; idle(2); s_btn = 0; idle(10); fs_step();
    for (int k = 0; k < 3; k++) begin
      press(10); idle(5); fs_step(); idle(2);
    end

    // Sample coinciding with frame start seeds the next frame on channel 0
    sample(0, 12'd500); idle(2);
    s_valid = 4'b0001; s_data[0] = 12'd30; s_fs = 1; step(); s_fs = 0; s_valid = '0;
    idle(3); fs_step(); idle(2);

    // Auto-rotate, then a button press landing on an auto advance
    s_auto = 1;
    repeat (7) begin idle(4); fs_step(); end
    idle(2); fs_step();
    press(10); fs_step();
    s_auto = 0; idle(2);

    // Reset mid-frame with non-zero peaks
    s_valid = 4'hF; idle(3); fs_step(); s_valid = 4'b0110; idle(3);
    rst = 1; step(); rst = 0;
    s_valid = 4'b1010; idle(2); s_valid = '0; idle(1);

    // Randomised traffic
    repeat (3000) begin
      s_valid = 4'($urandom);
      for (int i = 0; i < 4; i++)
        s_data[i] = ($urandom_range(0, 15) == 0) ? 12'h800 : 12'($urandom);
      s_fs = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) s_btn = ~s_btn;
      if ($urandom_range(0, 199) == 0) s_auto = ~s_auto;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; s_valid = '0; s_fs = 0;
    idle(3);
    @(negedge clk);
    #1;
    chk("frame_queue_drained", 32'(q_frm.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
